// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame receiver.
// Optional feature macro used by this block: RX_TIMEOUT_EN.
package uart_frame_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 16;
    localparam int unsigned DEF_NUM_CHANNEL  = 4;
    localparam int unsigned DEF_NUM_PIXEL    = 16;
    localparam int unsigned DEF_PIXEL_WIDTH  = 16;
    localparam int unsigned DEF_TIMEOUT_BITS = 32;
    localparam int unsigned BYTE_W           = 8;

    // Byte receiver states
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t eRxIdle  = 2'd0;
    localparam rx_state_t eRxStart = 2'd1;
    localparam rx_state_t eRxData  = 2'd2;
    localparam rx_state_t eRxStop  = 2'd3;

    // Pixels travel low byte first; rebuild as {high, low}
    function automatic logic [2*BYTE_W-1:0] join_bytes(input logic [BYTE_W-1:0] hi,
                                                        input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/uart_frame_receiver_rx_byte.sv
// 8N1 byte receiver: input synchroniser plus start/data/stop state machine.
// Strobe outputs are combinational (_c) so the assembler can register them with one clock of latency.
module uart_rx_byte
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              serialIn,
    output logic              byte_valid_c,
    output logic [BYTE_W-1:0] byte_data_c,
    output logic              framing_err_c,
    output logic              rx_idle_c,
    output logic              start_edge_c
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

    logic [1:0]        sync_q, sync_d;
    logic              prev_q, prev_d;
    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              rx_c;
    logic              bit_end_c;

    assign rx_c      = sync_q[1];
    assign bit_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // State register and synchroniser; line idles high out of reset
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            state_q   <= eRxIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: wait half a bit to qualify the start, then sample mid-bit
    always_comb begin
        sync_d        = {sync_q[0], serialIn};
        prev_d        = rx_c;
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_valid_c  = 1'b0;
        framing_err_c = 1'b0;
        start_edge_c  = 1'b0;

        case (state_q)
            eRxIdle: begin
                cnt_d = '0;
                if (prev_q && !rx_c) begin
                    start_edge_c = 1'b1;
                    state_d      = eRxStart;
                end
            end
            eRxStart: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_c ? eRxIdle : eRxData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            eRxData: begin
                if (bit_end_c) begin
                    cnt_d     = '0;
                    shift_d   = {rx_c, shift_q[BYTE_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = eRxStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            eRxStop: begin
                if (bit_end_c) begin
                    // Leave mid stop bit so a back-to-back start edge is not missed
                    cnt_d         = '0;
                    byte_valid_c  = rx_c;
                    framing_err_c = !rx_c;
                    state_d       = eRxIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = eRxIdle;
            end
        endcase
    end

    assign byte_data_c = shift_q;
    assign rx_idle_c   = (state_q == eRxIdle);

endmodule

// File: rtl/uart_frame_receiver.sv
// UART frame receiver: pairs received bytes into 16-bit pixels tagged with channel/pixel index.
// Optional macro RX_TIMEOUT_EN adds an idle timer that aborts a partial frame.
module uart_frame_receiver
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned NUM_CHANNEL  = DEF_NUM_CHANNEL,
    parameter int unsigned NUM_PIXEL    = DEF_NUM_PIXEL,
    parameter int unsigned PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int unsigned TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic                           clk,
    input  logic                           nRST,
    input  logic                           serialIn,
    output logic                           pixelValid,
    output logic [15:0]                    pixelData,
    output logic [$clog2(NUM_CHANNEL)-1:0] channelIdx,
    output logic [$clog2(NUM_PIXEL)-1:0]   pixelIdx,
    output logic                           frameDone,
    output logic                           framingErr,
    output logic                           rxTimeout
);

    localparam int unsigned CH_W = $clog2(NUM_CHANNEL);
    localparam int unsigned PX_W = $clog2(NUM_PIXEL);

    // Parameter sanity checks at elaboration
    if (PIXEL_WIDTH != 16) begin : g_bad_pixel_width
        $error("uart_frame_receiver: PIXEL_WIDTH must be 16");
    end
    if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_clks_per_bit
        $error("uart_frame_receiver: CLKS_PER_BIT must be even and >= 4");
    end

    logic              byte_valid_c;
    logic [BYTE_W-1:0] byte_data_c;
    logic              framing_err_c;
    logic              rx_idle_c;
    logic              start_edge_c;
    logic              timeout_fire_c;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk           (clk),
        .nRST          (nRST),
        .serialIn      (serialIn),
        .byte_valid_c  (byte_valid_c),
        .byte_data_c   (byte_data_c),
        .framing_err_c (framing_err_c),
        .rx_idle_c     (rx_idle_c),
        .start_edge_c  (start_edge_c)
    );

    logic              have_low_q, have_low_d;
    logic [BYTE_W-1:0] low_q, low_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic [15:0]       pixel_data_q, pixel_data_d;
    logic [CH_W-1:0]   ch_out_q, ch_out_d;
    logic [PX_W-1:0]   px_out_q, px_out_d;
    logic              frame_done_q, frame_done_d;
    logic              framing_err_q, framing_err_d;

`ifdef RX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned TB_W  = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;

    logic [CNT_W-1:0] to_clk_q, to_clk_d;
    logic [TB_W-1:0]  to_bits_q, to_bits_d;
    logic             rx_timeout_q;
    logic             at_frame_start_c;

    assign at_frame_start_c = !have_low_q && (ch_q == '0) && (px_q == '0);

    // Idle bit-time counter; only runs while a partial frame is waiting
    always_comb begin
        to_clk_d       = to_clk_q;
        to_bits_d      = to_bits_q;
        timeout_fire_c = 1'b0;
        if (start_edge_c || !rx_idle_c || at_frame_start_c) begin
            to_clk_d  = '0;
            to_bits_d = '0;
        end else if (to_clk_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            to_clk_d = '0;
            if (to_bits_q == TB_W'(TIMEOUT_BITS - 1)) begin
                to_bits_d      = '0;
                timeout_fire_c = 1'b1;
            end else begin
                to_bits_d = to_bits_q + 1'b1;
            end
        end else begin
            to_clk_d = to_clk_q + 1'b1;
        end
    end

    // Timer registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            to_clk_q     <= '0;
            to_bits_q    <= '0;
            rx_timeout_q <= 1'b0;
        end else begin
            to_clk_q     <= to_clk_d;
            to_bits_q    <= to_bits_d;
            rx_timeout_q <= timeout_fire_c;
        end
    end

    assign rxTimeout = rx_timeout_q;
`else
    logic unused_timer_c;

    assign timeout_fire_c = 1'b0;
    assign unused_timer_c = rx_idle_c ^ start_edge_c;
    assign rxTimeout      = 1'b0;
`endif

    // Assembler: low byte is held, high byte completes a pixel and advances channel/pixel index
    always_comb begin
        have_low_d    = have_low_q;
        low_d         = low_q;
        ch_d          = ch_q;
        px_d          = px_q;
        pixel_valid_d = 1'b0;
        pixel_data_d  = pixel_data_q;
        ch_out_d      = ch_out_q;
        px_out_d      = px_out_q;
        frame_done_d  = 1'b0;
        framing_err_d = framing_err_c;

        if (byte_valid_c) begin
            if (!have_low_q) begin
                low_d      = byte_data_c;
                have_low_d = 1'b1;
            end else begin
                have_low_d    = 1'b0;
                pixel_valid_d = 1'b1;
                pixel_data_d  = join_bytes(byte_data_c, low_q);
                ch_out_d      = ch_q;
                px_out_d      = px_q;
                if (ch_q == CH_W'(NUM_CHANNEL - 1)) begin
                    ch_d = '0;
                    if (px_q == PX_W'(NUM_PIXEL - 1)) begin
                        px_d         = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
        end else if (timeout_fire_c) begin
            have_low_d = 1'b0;
            ch_d       = '0;
            px_d       = '0;
        end
    end

    // Assembler and output registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            have_low_q    <= 1'b0;
            low_q         <= '0;
            ch_q          <= '0;
            px_q          <= '0;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= '0;
            ch_out_q      <= '0;
            px_out_q      <= '0;
            frame_done_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            have_low_q    <= have_low_d;
            low_q         <= low_d;
            ch_q          <= ch_d;
            px_q          <= px_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_data_q  <= pixel_data_d;
            ch_out_q      <= ch_out_d;
            px_out_q      <= px_out_d;
            frame_done_q  <= frame_done_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign pixelValid = pixel_valid_q;
    assign pixelData  = pixel_data_q;
    assign channelIdx = ch_out_q;
    assign pixelIdx   = px_out_q;
    assign frameDone  = frame_done_q;
    assign framingErr = framing_err_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Scoreboard bench for uart_frame_receiver: stimulus pushes expected pixels, a monitor pops and compares.
module tb_uart_frame_receiver;

    localparam int unsigned CPB = 16;
    localparam int unsigned NC  = 4;
    localparam int unsigned NP  = 16;

    logic        clk = 1'b0;
    logic        nRST;
    logic        serialIn;
    logic        pixelValid;
    logic [15:0] pixelData;
    logic [1:0]  channelIdx;
    logic [3:0]  pixelIdx;
    logic        frameDone;
    logic        framingErr;
    logic        rxTimeout;

    always #5 clk = ~clk;

    uart_frame_receiver #(
        .CLKS_PER_BIT (CPB),
        .NUM_CHANNEL  (NC),
        .NUM_PIXEL    (NP),
        .PIXEL_WIDTH  (16),
        .TIMEOUT_BITS (32)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .serialIn   (serialIn),
        .pixelValid (pixelValid),
        .pixelData  (pixelData),
        .channelIdx (channelIdx),
        .pixelIdx   (pixelIdx),
        .frameDone  (frameDone),
        .framingErr (framingErr),
        .rxTimeout  (rxTimeout)
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  ch;
        logic [3:0]  px;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int vectors     = 0;
    int miscompares = 0;
    int fe_seen = 0, fe_exp = 0;
    int to_seen = 0, to_exp = 0;

    // Reference model: count of completed pixels since frame start, plus pending low byte
    int unsigned pix_cnt   = 0;
    bit          have_low  = 1'b0;
    logic [7:0]  low_byte  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        pix_cnt  = 0;
        have_low = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (!have_low) begin
            low_byte = b;
            have_low = 1'b1;
        end else begin
            e.data   = {b, low_byte};
            e.ch     = 2'(pix_cnt % NC);
            e.px     = 4'((pix_cnt / NC) % NP);
            e.done   = ((pix_cnt % (NC * NP)) == (NC * NP - 1));
            exp_q.push_back(e);
            pix_cnt++;
            have_low = 1'b0;
        end
    endtask

    // Drive one 8N1 frame, optionally truncated after 'limit' clocks
    task automatic drive_frame(input logic [7:0] b, input bit stop, input int limit);
        logic [9:0] frm;
        frm = {stop, b, 1'b0};
        for (int i = 0; i < 10 * CPB && i < limit; i++) begin
            serialIn = frm[i / CPB];
            @(negedge clk);
        end
        serialIn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        if (stop_ok) model_byte(b);
        else         fe_exp++;
        drive_frame(b, stop_ok, 10 * CPB);
        repeat (gap_bits * CPB) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending_pixels", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        serialIn = 1'b1;
        nRST     = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pixelValid"}, 32'(pixelValid), 32'd0);
        check({tag, "_pixelData"},  32'(pixelData),  32'd0);
        check({tag, "_channelIdx"}, 32'(channelIdx), 32'd0);
        check({tag, "_pixelIdx"},   32'(pixelIdx),   32'd0);
        check({tag, "_frameDone"},  32'(frameDone),  32'd0);
        check({tag, "_framingErr"}, 32'(framingErr), 32'd0);
        check({tag, "_rxTimeout"},  32'(rxTimeout),  32'd0);
    endtask

    // Monitor: compares every pixel strobe against the scoreboard head
    always @(negedge clk) begin
        if (nRST === 1'b1) begin
            if (framingErr === 1'b1) fe_seen++;
            if (rxTimeout === 1'b1)  to_seen++;
            if (pixelValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", {16'h0, pixelData}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixelData",  32'(pixelData),  32'(mon_e.data));
                    check("channelIdx", 32'(channelIdx), 32'(mon_e.ch));
                    check("pixelIdx",   32'(pixelIdx),   32'(mon_e.px));
                    check("frameDone",  32'(frameDone),  32'(mon_e.done));
                end
            end else if (frameDone === 1'b1) begin
                check("frameDone_without_pixel", 32'(frameDone), 32'd0);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pix;
        logic [7:0]  rb;
        bit          ok;

        nRST     = 1'b0;
        serialIn = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        nRST = 1'b1;
        repeat (4) @(negedge clk);

        // Single pixel 0x1234
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 2);
        wait_drain();

        // Full frame back-to-back, pixel k = k, then start of a second frame
        do_reset();
        for (int k = 0; k < int'(NC * NP); k++) begin
            pix = 16'(k);
            send_byte(pix[7:0],  1'b1, 0);
            send_byte(pix[15:8], 1'b1, 0);
        end
        for (int k = 0; k < 8; k++) begin
            pix = 16'($urandom);
            send_byte(pix[7:0],  1'b1, 0);
            send_byte(pix[15:8], 1'b1, 0);
        end
        wait_drain();

        // Start glitch: 4 clocks low, then a normal pair
        do_reset();
        serialIn = 1'b0;
        repeat (4) @(negedge clk);
        serialIn = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_framingErr_count", 32'(fe_seen), 32'(fe_exp));
        send_byte(8'h78, 1'b1, 0);
        send_byte(8'h56, 1'b1, 1);
        wait_drain();

        // Stop bit forced low, then a good pair
        do_reset();
        send_byte(8'h55, 1'b0, 2);
        check("framingErr_count", 32'(fe_seen), 32'(fe_exp));
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 1);
        wait_drain();

        // Reset in the middle of the high byte's data bits
        do_reset();
        send_byte(8'hEF, 1'b1, 0);
        drive_frame(8'h99, 1'b1, 60);
        nRST = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        @(negedge clk);
        nRST = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        send_byte(8'hCD, 1'b1, 0);
        send_byte(8'hAB, 1'b1, 1);
        wait_drain();

        // Partial frame followed by a long idle period
        do_reset();
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1, 0);
        wait_drain();
        repeat (40 * CPB) @(negedge clk);
`ifdef RX_TIMEOUT_EN
        model_reset();
        to_exp++;
`endif
        check("timeout_count", 32'(to_seen), 32'(to_exp));
        send_byte(8'h0F, 1'b1, 0);
        send_byte(8'hF0, 1'b1, 1);
        wait_drain();

        // Randomised stream with occasional framing errors and short gaps
        do_reset();
        for (int k = 0; k < 60; k++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(7) != 0);
            send_byte(rb, ok, ok ? int'($urandom_range(2)) : 1 + int'($urandom_range(1)));
        end
        wait_drain();

        check("final_framingErr_count", 32'(fe_seen), 32'(fe_exp));
        check("final_timeout_count",    32'(to_seen), 32'(to_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
